// File: rtl/dmem_host_port.sv
// Host-side data-memory port: loads an image while the core is held, runs the
// core until done (or timeout), then streams a readback window out.
module dmem_host_port #(
    parameter int unsigned AW  = 8,
    parameter int unsigned DW  = 8,
    parameter int unsigned TMO = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] ld_base,
    input  logic [AW:0]   ld_len,
    input  logic [AW-1:0] rd_base,
    input  logic [AW:0]   rd_len,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          core_hold,
    input  logic          core_done,
    output logic          host_owns,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          sess_done,
    output logic          timeout
);

    localparam int unsigned CW = AW + 1;
    localparam int unsigned RW = 16;
    localparam logic [CW-1:0] MAX_LEN  = CW'(1) << AW;
    localparam logic [RW-1:0] RUN_LAST = RW'(TMO - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [CW-1:0] rd_len_q, rd_len_d;
    logic [RW-1:0] run_cnt_q, run_cnt_d;
    logic          timeout_q, timeout_d;
    logic          sess_done_q, sess_done_d;
    logic [CW-1:0] ld_len_cl;

    function automatic logic [CW-1:0] clamp_len(input logic [CW-1:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            rd_base_q   <= '0;
            rd_len_q    <= '0;
            run_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            sess_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            rd_base_q   <= rd_base_d;
            rd_len_q    <= rd_len_d;
            run_cnt_q   <= run_cnt_d;
            timeout_q   <= timeout_d;
            sess_done_q <= sess_done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        rd_base_d   = rd_base_q;
        rd_len_d    = rd_len_q;
        run_cnt_d   = run_cnt_q;
        timeout_d   = timeout_q;
        sess_done_d = 1'b0;
        ld_len_cl   = clamp_len(ld_len);
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_last    = 1'b0;
        mem_wr_en   = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        core_hold   = 1'b1;
        host_owns   = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d    = ld_base;
                    cnt_d     = ld_len_cl;
                    rd_base_d = rd_base;
                    rd_len_d  = clamp_len(rd_len);
                    run_cnt_d = '0;
                    timeout_d = 1'b0;
                    state_d   = (ld_len_cl != '0) ? S_LOAD : S_RUN;
                end
            end
            S_LOAD: begin
                in_ready  = 1'b1;
                mem_wr_en = in_valid;
                mem_addr  = addr_q;
                mem_wdata = in_data;
                if (in_valid) begin
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        run_cnt_d = '0;
                        state_d   = S_RUN;
                    end
                end
            end
            S_RUN: begin
                core_hold = 1'b0;
                host_owns = 1'b0;
                run_cnt_d = run_cnt_q + RW'(1);
                // A done level left over from a previous run is masked in the first cycle.
                if (core_done && run_cnt_q != '0) begin
                    if (rd_len_q == '0) begin
                        state_d     = S_IDLE;
                        sess_done_d = 1'b1;
                    end else begin
                        addr_d  = rd_base_q;
                        cnt_d   = rd_len_q;
                        state_d = S_DRAIN;
                    end
                end else if (run_cnt_q == RUN_LAST) begin
                    state_d     = S_IDLE;
                    timeout_d   = 1'b1;
                    sess_done_d = 1'b1;
                end
            end
            S_DRAIN: begin
                out_valid = 1'b1;
                mem_addr  = addr_q;
                out_last  = (cnt_q == CW'(1));
                if (out_ready) begin
                    addr_d = addr_q + AW'(1);
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d     = S_IDLE;
                        sess_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign out_data  = mem_rdata;
    assign busy      = (state_q != S_IDLE);
    assign sess_done = sess_done_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_dmem_host_port.sv
// Randomized scoreboard bench for dmem_host_port with a behavioural memory image model.
module tb_dmem_host_port;

    localparam int TMO = 32;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] ld_base, rd_base;
    logic [8:0] ld_len, rd_len;
    logic       in_valid, in_ready;
    logic [7:0] in_data;
    logic       out_valid, out_last, out_ready;
    logic [7:0] out_data;
    logic       core_hold, core_done, host_owns;
    logic       mem_wr_en;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;
    logic       busy, sess_done, timeout;

    logic       pre_we;
    logic [7:0] pre_addr, pre_data;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    exp_t wq[$];
    exp_t rq[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   exp_to = 1'b0;

    always #5 clk = ~clk;

    dmem_host_port #(.AW(8), .DW(8), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ld_base(ld_base), .ld_len(ld_len), .rd_base(rd_base), .rd_len(rd_len),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .core_hold(core_hold), .core_done(core_done), .host_owns(host_owns),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .sess_done(sess_done), .timeout(timeout)
    );

    // Data memory stand-in: synchronous write, combinational read.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
    end
    assign mem_rdata = mem[mem_addr];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void chk_empty(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: DUT output with no expected entry at %0t", name, $time);
    endfunction

    // Monitor: pops expected writes and readback bytes as the DUT presents them.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset) begin
            if (mem_wr_en) begin
                if (wq.size() == 0) chk_empty("unexpected_write");
                else begin
                    e = wq.pop_front();
                    chk("wr_addr", 32'(mem_addr), 32'(e.addr));
                    chk("wr_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (out_valid) begin
                if (rq.size() == 0) chk_empty("unexpected_out_valid");
                else begin
                    e = rq[0];
                    chk("rd_addr", 32'(mem_addr), 32'(e.addr));
                    chk("rd_data", 32'(out_data), 32'(e.data));
                    chk("rd_last", 32'(out_last), 32'(e.last));
                    if (out_ready) void'(rq.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // dly = 0: core never finishes; otherwise done is raised dly cycles into RUN.
    task automatic session(input int lb, input int ll, input int rb, input int rl,
                           input int dly, input int vp, input int rp);
        int L, R, i, nrun;
        L = (ll > 256) ? 256 : ll;
        R = (rl > 256) ? 256 : rl;
        chk("timeout_before_start", 32'(timeout), 32'(exp_to));
        start   = 1'b1;
        ld_base = 8'(lb);
        ld_len  = 9'(ll);
        rd_base = 8'(rb);
        rd_len  = 9'(rl);
        tick();
        start   = 1'b0;
        ld_base = 8'($urandom);
        ld_len  = 9'($urandom);
        rd_base = 8'($urandom);
        rd_len  = 9'($urandom);
        exp_to  = 1'b0;
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("timeout_cleared", 32'(timeout), 32'd0);
        chk("in_ready_first", 32'(in_ready), (L == 0) ? 32'd0 : 32'd1);
        i = 0;
        while (i < L) begin
            chk("core_hold_load", 32'(core_hold), 32'd1);
            in_valid = ($urandom_range(0, 99) < vp);
            in_data  = 8'($urandom);
            start    = ($urandom_range(0, 7) == 0);
            if (in_valid) begin
                wq.push_back('{addr: 8'(lb + i), data: in_data, last: 1'b0});
                ref_mem[8'(lb + i)] = in_data;
                i++;
            end
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        chk("core_hold_run", 32'(core_hold), 32'd0);
        chk("host_owns_run", 32'(host_owns), 32'd0);
        nrun = (dly == 0) ? TMO : dly + 1;
        for (int c = 0; c < nrun; c++) begin
            if (dly == 0) core_done = 1'b0;
            else if (c == 0) core_done = 1'($urandom_range(0, 1));
            else core_done = (c >= dly);
            start = ($urandom_range(0, 7) == 0);
            tick();
        end
        core_done = 1'b0;
        start     = 1'b0;
        if (dly == 0) begin
            exp_to = 1'b1;
            chk("to_busy", 32'(busy), 32'd0);
            chk("to_flag", 32'(timeout), 32'd1);
            chk("to_sess_done", 32'(sess_done), 32'd1);
            chk("to_core_hold", 32'(core_hold), 32'd1);
        end else if (R == 0) begin
            chk("norb_busy", 32'(busy), 32'd0);
            chk("norb_sess_done", 32'(sess_done), 32'd1);
        end else begin
            for (int k = 0; k < R; k++)
                rq.push_back('{addr: 8'(rb + k), data: ref_mem[8'(rb + k)], last: (k == R - 1)});
            i = 0;
            while (i < R) begin
                chk("core_hold_drain", 32'(core_hold), 32'd1);
                out_ready = ($urandom_range(0, 99) < rp);
                start     = ($urandom_range(0, 7) == 0);
                if (out_ready) i++;
                tick();
            end
            out_ready = 1'b0;
            start     = 1'b0;
            chk("drain_end_busy", 32'(busy), 32'd0);
            chk("drain_end_sess_done", 32'(sess_done), 32'd1);
            chk("drain_end_timeout", 32'(timeout), 32'd0);
        end
        tick();
        chk("sess_done_one_cycle", 32'(sess_done), 32'd0);
        chk("idle_core_hold", 32'(core_hold), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; ld_base = '0; ld_len = '0; rd_base = '0; rd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0; core_done = 1'b0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int a = 0; a < 256; a++) begin
            pre_we   = 1'b1;
            pre_addr = 8'(a);
            pre_data = (a >= 8'h40 && a <= 8'h42) ? 8'(8'h11 * (a - 8'h3F)) : 8'($urandom);
            ref_mem[a] = pre_data;
            tick();
        end
        pre_we = 1'b0;
        tick();
        chk("rst_core_hold", 32'(core_hold), 32'd1);
        chk("rst_host_owns", 32'(host_owns), 32'd1);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'(ref_mem[0]));
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sess_done", 32'(sess_done), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;
        tick();

        session(8'h00, 0, 8'h40, 3, 20, 100, 100);   // preloaded 11,22,33 readback
        session(8'h10, 4, 8'h10, 4, 5, 100, 100);    // basic load
        session(8'hFE, 3, 8'hFE, 3, 7, 50, 30);      // wrap with back-pressure
        session(8'h30, 0, 8'h30, 0, 3, 100, 100);    // zero lengths
        session(8'h50, 2, 8'h50, 2, 0, 100, 100);    // timeout
        session(8'h50, 1, 8'h4F, 3, 2, 100, 60);     // timeout cleared by next start
        session(8'h80, 511, 8'h80, 300, TMO - 1, 100, 100); // length clamping

        // Reset in the middle of a five-byte load after two bytes landed.
        start = 1'b1; ld_base = 8'h20; ld_len = 9'd5; rd_base = 8'h20; rd_len = 9'd5;
        tick();
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            wq.push_back('{addr: 8'(8'h20 + b), data: in_data, last: 1'b0});
            ref_mem[8'(8'h20 + b)] = in_data;
            tick();
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk("mrst_core_hold", 32'(core_hold), 32'd1);
        chk("mrst_host_owns", 32'(host_owns), 32'd1);
        chk("mrst_in_ready", 32'(in_ready), 32'd0);
        chk("mrst_mem_addr", 32'(mem_addr), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("mrst_no_sess_done", 32'(sess_done), 32'd0);
        chk("mrst_idle", 32'(busy), 32'd0);
        session(8'h00, 0, 8'h20, 5, 4, 100, 70);     // partial load kept

        for (int s = 0; s < 25; s++) begin
            int ll, rl, dly;
            case ($urandom_range(0, 7))
                0: ll = 0;
                1: ll = 1;
                7: ll = $urandom_range(257, 511);
                default: ll = $urandom_range(2, 12);
            endcase
            case ($urandom_range(0, 5))
                0: rl = 0;
                1: rl = 1;
                default: rl = $urandom_range(2, 12);
            endcase
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TMO - 1);
            session($urandom_range(0, 255), ll, $urandom_range(0, 255), rl, dly,
                    $urandom_range(40, 100), $urandom_range(40, 100));
        end

        tick();
        chk("write_queue_drained", 32'(wq.size()), 32'd0);
        chk("read_queue_drained", 32'(rq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_host_port.md
# dmem_host_port

Host-side access port for the processor's data memory. It streams an input image into `dat_mem` while the core is held in reset, releases the core, and waits for the core's `done`. It then streams a result window back out of `dat_mem`. It sits between the testbench/host and the top level, and owns the data-memory port whenever the core is held.

## Interface
Parameters:
- `AW`, 8, data-memory address width (matches core `mem_addr`).
- `DW`, 8, data width.
- `TMO`, 4096, maximum RUN cycles before timeout (16-bit counter).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  session start pulse; sampled only in IDLE.
- `ld_base`  in  AW  first load address; captured at start.
- `ld_len`  in  AW+1  bytes to load, 0..256; captured at start.
- `rd_base`  in  AW  first readback address; captured at start.
- `rd_len`  in  AW+1  bytes to read back, 0..256; captured at start.
- `in_valid`  in  1  load byte valid.
- `in_data`  in  DW  load byte.
- `in_ready`  out  1  load byte accepted this cycle when `in_valid`.
- `out_valid`  out  1  readback byte valid.
- `out_data`  out  DW  readback byte.
- `out_last`  out  1  marks final readback byte.
- `out_ready`  in  1  host accepts readback byte.
- `core_hold`  out  1  holds core in reset; high in every state except RUN.
- `core_done`  in  1  core finished (level).
- `host_owns`  out  1  top level muxes data-memory port to this block.
- `mem_wr_en`  out  1  data-memory write strobe.
- `mem_addr`  out  AW  data-memory address.
- `mem_wdata`  out  DW  data-memory write data.
- `mem_rdata`  in  DW  data-memory read data; combinational read of `mem_addr`.
- `busy`  out  1  high when state is not IDLE.
- `sess_done`  out  1  one-cycle pulse on return to IDLE.
- `timeout`  out  1  sticky; cleared by next accepted `start`.

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- **IDLE:** `start`=1 captures the four window inputs, sets `addr`=`ld_base` and `cnt`=`ld_len`, and clears `timeout`.
  - Next state is LOAD if `ld_len`≠0, else RUN.
- **LOAD:**
  - `in_ready`=1 and `host_owns`=1.
  - `mem_wr_en`=`in_valid`, `mem_addr`=`addr`, `mem_wdata`=`in_data`.
  - Each accepted byte does `addr`+1 mod 2^AW (wrap 255→0) and `cnt`−1.
  - Acceptance with `cnt`=1 → RUN.
- **RUN:**
  - `core_hold`=0, `host_owns`=0, `mem_wr_en`=0.
  - The run counter clears on entry. `core_done` is ignored in the first RUN cycle.
  - `core_done`=1 → DRAIN, loading `addr`=`rd_base` and `cnt`=`rd_len`.
  - If `rd_len`=0, go to IDLE instead.
  - Counter reaching `TMO` without `core_done` → IDLE with `timeout`=1; there is no readback.
- **DRAIN:**
  - `host_owns`=1 and `out_valid`=1.
  - `mem_addr`=`addr`, `out_data`=`mem_rdata`, `out_last`=(`cnt`=1).
  - On `out_valid`&`out_ready`, `addr` increments with wrap and `cnt` decrements.
  - Last handshake → IDLE.
- `sess_done` pulses in the first IDLE cycle after any session end, including timeout.
- `start` outside IDLE is ignored.
- Window inputs may change freely after capture.
- `ld_len` or `rd_len` > 256 is clamped to 256.

## Timing
- **Reset values:**
  - State IDLE.
  - `core_hold`=1, `host_owns`=1.
  - `in_ready`=0, `out_valid`=0, `out_last`=0, `mem_wr_en`=0.
  - `mem_addr`=0, `mem_wdata`=0, `out_data` follows `mem_rdata`.
  - `busy`=0, `sess_done`=0, `timeout`=0.
- `start` at edge N → LOAD (or RUN) visible in cycle N+1.
- Load write commits at the edge where `in_valid`&`in_ready`; one byte per cycle maximum, no bubbles required.
- LOAD→RUN: `core_hold` falls in the cycle after the last accepted byte.
- RUN→DRAIN: first `out_valid` in the cycle after `core_done` is sampled. `core_hold` rises in that same cycle.
- DRAIN: while `out_valid`&!`out_ready`, `mem_addr`, `out_data` and `out_last` hold stable. Throughput is one byte per cycle.
- Reset asserted mid-session: immediate return to reset values. The partial load is not undone, and `sess_done` does not pulse.

## Test plan
- **Basic load:** reset, then `start` with `ld_base`=0x10, `ld_len`=4, bytes A1..A4 streamed with `in_valid` always high.
  - Writes land at 0x10..0x13 on consecutive edges.
  - `core_hold` falls 1 cycle after the 4th byte.
- **Full session:** `core_done` raised 20 cycles into RUN, `rd_base`=0x40, `rd_len`=3, memory preloaded 0x40..0x42 = 11,22,33.
  - Output is 11,22,33.
  - `out_last` is set only on 33.
  - `sess_done` pulses once, then `busy`=0.
- **Wrap and back-pressure:** `ld_base`=0xFE, `ld_len`=3, `in_valid` toggling.
  - Writes go to 0xFE, 0xFF, 0x00.
  - Readback with `out_ready` low for 3 cycles holds `out_data` stable.
- **Zero lengths:** `ld_len`=0, `rd_len`=0.
  - IDLE→RUN directly.
  - `core_done` → IDLE with no `out_valid`.
- **Timeout:** `TMO`=16, `core_done` never asserted.
  - IDLE after 16 RUN cycles with `timeout`=1 and `sess_done` pulsed.
  - Next `start` clears `timeout`.
- **Mid-session reset:** reset asserted during LOAD after 2 of 5 bytes.
  - Outputs immediately return to reset values.
  - `start` is ignored during the session and accepted again afterward.
